// File: rtl/pspin_cfg_pkg.sv
// Shared packet-scheduler types: the task descriptor sent down to a cluster,
// the feedback descriptor returned upstream, and the cluster dispatch FSM
// state encoding.
package pspin_cfg_pkg;

    // Largest cluster the dispatcher is intended to serve.
    localparam int unsigned MAX_HPUS_PER_CLUSTER = 16;

    // Handler task handed from the global scheduler to a cluster.
    typedef struct packed {
        logic [15:0] msgid;
        logic [31:0] handler_addr;
        logic [31:0] pkt_addr;
        logic [15:0] pkt_size;
    } handler_task_t;

    // Completion record returned by an HPU and forwarded upstream.
    typedef struct packed {
        logic [15:0] msgid;
        logic [31:0] pkt_addr;
        logic [15:0] pkt_size;
    } feedback_descr_t;

    // Dispatch FSM: IDLE picks a free HPU, OFFER holds the task until taken.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } dispatch_state_t;

endpackage

// File: rtl/cluster_task_queue.sv
// Synchronous FIFO holding handler tasks waiting for a free HPU.
// The element type and depth are parameters; depth must be a power of two.
// Push while full and pop while empty are ignored. The head entry is read
// combinationally and stays stable until it is popped.
module cluster_task_queue #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cluster_task_dispatcher.sv
// Cluster-side endpoint of the scheduler task/feedback interface.
// Tasks are queued, then offered one at a time to the lowest-index idle HPU.
// HPU completions are arbitrated round-robin into a single feedback register
// and returned upstream, one feedback per dispatched task.
//
// Handshake rule for every port pair: a transfer happens in a cycle where
// valid and ready are both high; a valid is held, with its payload stable,
// until that transfer happens.
//
// Optional build macro CLUSTER_DISPATCH_STATS_EN adds 32-bit wrapping
// counters of HPU dispatches (tasks_dispatched_o) and feedback transfers
// (feedbacks_sent_o).
module cluster_task_dispatcher
    import pspin_cfg_pkg::*;
#(
    parameter int unsigned NUM_HPUS        = 8,
    parameter int unsigned TASK_FIFO_DEPTH = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  task_valid_i,
    output logic                                  task_ready_o,
    input  handler_task_t                         task_descr_i,
    output logic            [NUM_HPUS-1:0]        hpu_task_valid_o,
    input  logic            [NUM_HPUS-1:0]        hpu_task_ready_i,
    output handler_task_t                         hpu_task_o,
    input  logic            [NUM_HPUS-1:0]        hpu_done_valid_i,
    output logic            [NUM_HPUS-1:0]        hpu_done_ready_o,
    input  feedback_descr_t [NUM_HPUS-1:0]        hpu_done_i,
    output logic                                  feedback_valid_o,
    input  logic                                  feedback_ready_i,
    output feedback_descr_t                       feedback_o,
    output logic            [NUM_HPUS-1:0]        busy_o
`ifdef CLUSTER_DISPATCH_STATS_EN
    ,
    output logic            [31:0]                tasks_dispatched_o,
    output logic            [31:0]                feedbacks_sent_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_HPUS);

    // ------------------------------------------------------------------
    // Task queue
    // ------------------------------------------------------------------
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    handler_task_t q_head;

    // Ready depends only on registered occupancy, never on task_valid_i.
    // It is held low while reset is asserted.
    assign task_ready_o = ~q_full & ~rst_i;
    assign q_push       = task_valid_i & task_ready_o;

    cluster_task_queue #(
        .T     (handler_task_t),
        .DEPTH (TASK_FIFO_DEPTH)
    ) u_task_queue (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (q_push),
        .push_data (task_descr_i),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // ------------------------------------------------------------------
    // Busy bitmap and lowest idle HPU
    // ------------------------------------------------------------------
    logic [NUM_HPUS-1:0] busy_q;
    logic [NUM_HPUS-1:0] busy_set;
    logic [NUM_HPUS-1:0] busy_clr;
    logic                idle_any;
    logic [IDX_W-1:0]    idle_idx;

    assign busy_o = busy_q;

    // Find the lowest-index HPU whose busy bit is clear.
    always_comb begin
        idle_any = ~(&busy_q);
        idle_idx = '0;
        for (int i = NUM_HPUS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                idle_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    dispatch_state_t  state_q;
    dispatch_state_t  state_d;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] sel_d;
    logic             dispatch_fire;

    // State and selected-HPU registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next state and offer outputs; the offered task is the queue head,
    // which cannot change while OFFER holds because only OFFER pops.
    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        hpu_task_valid_o = '0;
        hpu_task_o       = '0;
        q_pop            = 1'b0;
        dispatch_fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!q_empty && idle_any) begin
                    sel_d   = idle_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                hpu_task_valid_o = NUM_HPUS'(1) << sel_q;
                hpu_task_o       = q_head;
                if (hpu_task_ready_i[sel_q]) begin
                    q_pop         = 1'b1;
                    dispatch_fire = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Completion arbitration and feedback register
    // ------------------------------------------------------------------
    logic [NUM_HPUS-1:0] eligible;
    logic                grant_any;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W:0]      rr_sum;
    logic [IDX_W-1:0]    rr_cand;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    rr_next;
    logic                fb_load;
    logic                fb_valid_q;
    feedback_descr_t     fb_q;

    // Only HPUs we actually dispatched to may complete.
    assign eligible = hpu_done_valid_i & busy_q;

    // Round-robin search starting at the pointer, wrapping at NUM_HPUS.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int i = 0; i < NUM_HPUS; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (rr_sum >= (IDX_W+1)'(NUM_HPUS)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_HPUS);
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (!grant_any && eligible[rr_cand]) begin
                grant_any = 1'b1;
                grant_idx = rr_cand;
            end
        end
    end

    // Next pointer sits just past the granted HPU.
    assign rr_next = (grant_idx == IDX_W'(NUM_HPUS - 1)) ? '0 : grant_idx + 1'b1;

    // A completion is taken only if the feedback register is free this cycle.
    assign fb_load          = grant_any & (~fb_valid_q | feedback_ready_i);
    assign hpu_done_ready_o = fb_load ? (NUM_HPUS'(1) << grant_idx) : '0;
    assign feedback_valid_o = fb_valid_q;
    assign feedback_o       = fb_q;

    assign busy_set = dispatch_fire ? (NUM_HPUS'(1) << sel_q) : '0;
    assign busy_clr = hpu_done_ready_o;

    // Busy bitmap: set on dispatch, clear on completion; the two always hit
    // different HPUs since a busy HPU is never selected.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q | busy_set) & ~busy_clr;
        end
    end

    // Feedback register and arbitration pointer; load wins over drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fb_valid_q <= 1'b0;
            fb_q       <= '0;
            rr_ptr_q   <= '0;
        end else if (fb_load) begin
            fb_valid_q <= 1'b1;
            fb_q       <= hpu_done_i[grant_idx];
            rr_ptr_q   <= rr_next;
        end else if (feedback_ready_i) begin
            fb_valid_q <= 1'b0;
        end
    end

`ifdef CLUSTER_DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    logic [31:0] tasks_dispatched_q;
    logic [31:0] feedbacks_sent_q;

    // Count dispatch and feedback transfers, wrapping at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tasks_dispatched_q <= '0;
            feedbacks_sent_q   <= '0;
        end else begin
            if (dispatch_fire) begin
                tasks_dispatched_q <= tasks_dispatched_q + 32'd1;
            end
            if (fb_valid_q && feedback_ready_i) begin
                feedbacks_sent_q <= feedbacks_sent_q + 32'd1;
            end
        end
    end

    assign tasks_dispatched_o = tasks_dispatched_q;
    assign feedbacks_sent_o   = feedbacks_sent_q;
`endif

endmodule

// File: doc/cluster_task_dispatcher.md
# cluster_task_dispatcher

Cluster-side endpoint of the packet scheduler's task/feedback interface. Accepts handler tasks from the global scheduler, queues them, and dispatches each to an idle HPU in the cluster. Collects HPU completions and returns them upstream as feedback descriptors, one per task. This keeps the global scheduler's per-cluster occupancy count balanced.

## Interface
- NUM_HPUS, 8: HPUs served by this cluster (2..16).
- TASK_FIFO_DEPTH, 4: task queue entries (power of two, ≥2).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- task_valid_i  in  1  task offered by global scheduler.
- task_ready_o  out  1  task queue can accept.
- task_descr_i  in  handler_task_t  task descriptor.
- hpu_task_valid_o  out  NUM_HPUS  one-hot task offer to HPU i.
- hpu_task_ready_i  in  NUM_HPUS  HPU i accepts the task.
- hpu_task_o  out  handler_task_t  task at the queue head, shared by all HPUs.
- hpu_done_valid_i  in  NUM_HPUS  HPU i reports completion.
- hpu_done_ready_o  out  NUM_HPUS  completion from HPU i taken.
- hpu_done_i  in  feedback_descr_t[NUM_HPUS]  completion descriptors.
- feedback_valid_o  out  1  feedback to global scheduler.
- feedback_ready_i  in  1  feedback accepted.
- feedback_o  out  feedback_descr_t  feedback descriptor.
- busy_o  out  NUM_HPUS  HPU busy bitmap.

## Operation
- Task queue:
  - task_ready_o = !full. There is no combinational pass-through.
  - A push occurs on valid&ready.
  - Push and pop in the same cycle are both performed, and the count is unchanged.
- Dispatch FSM, states IDLE and OFFER:
  - IDLE: if the queue is non-empty and busy_q has a zero bit, latch sel_q = lowest-index idle HPU and go to OFFER.
  - OFFER: hpu_task_valid_o[sel_q]=1 and hpu_task_o = queue head, held stable.
  - On hpu_task_ready_i[sel_q]: pop the queue, set busy_q[sel_q], return to IDLE.
  - Ready on a non-selected HPU is ignored.
- Completion path:
  - Round-robin arbitration over hpu_done_valid_i & busy_q. The pointer advances past the granted index.
  - The grant is accepted only when the feedback register is empty or is draining this cycle.
  - On accept: hpu_done_ready_o[g]=1, the descriptor is loaded into the feedback register, and busy_q[g] is cleared.
  - Done from a non-busy HPU is never granted (ready stays 0).
- Same-cycle set and clear of busy_q on different HPUs are both applied.
- Dispatch selection uses busy_q only, so an HPU freed in cycle N is selectable in cycle N+1.

## Timing
- Reset: all outputs 0, except task_ready_o=1 from the first cycle after reset deasserts. Queue is empty, busy_q=0, FSM is IDLE, RR pointer=0.
- Reset mid-operation:
  - Queued tasks, pending offers and the held feedback are discarded.
  - The global scheduler's occupancy must be reset concurrently.
- Task accepted at cycle N: earliest hpu_task_valid_o at cycle N+2 (N+1 IDLE select, N+2 OFFER).
- Back-to-back dispatches: one per 2 cycles.
- Completion accepted at cycle N: feedback_valid_o at N+1.
  - The feedback register is held until feedback_ready_i.
  - With the sink always ready, throughput is one feedback per cycle.
- All valids are held until their handshake completes. Descriptors are stable while valid.

## Configuration
- CLUSTER_DISPATCH_STATS_EN.
- Defined: adds output ports tasks_dispatched_o and feedbacks_sent_o, 32 bits each.
  - They increment on an HPU dispatch handshake and on a feedback handshake respectively.
  - They wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- handler_task_t and feedback_descr_t come from pspin_cfg_pkg.
- Add to pspin_cfg_pkg: dispatch_state_t enum (IDLE, OFFER).
- One sub-module, cluster_task_queue: synchronous FIFO with active-high sync reset, parameterised by type and depth, full/empty flags.
- The FSM, busy bitmap and RR arbiter are inline.

## Test plan
- Reset then one task (msgid=5), all HPUs ready -> hpu_task_valid_o=8'b0000_0001 two cycles later; busy_o=1.
- Fill 4 tasks with no HPU ready -> task_ready_o=0 after the 4th; offer to HPU0 held stable; 5th task stalled until pop.
- 9 tasks with NUM_HPUS=8, no completions -> HPUs 0..7 busy, 9th held in queue; done from HPU3 -> 9th dispatched to HPU3.
- HPUs 1, 2 and 6 signal done simultaneously with feedback_ready_i=1 -> feedback msgids in order 1, 2, 6 on consecutive cycles.
- feedback_ready_i=0 for 10 cycles with 2 dones pending -> feedback_o stable, second done unacknowledged; both delivered once ready.
- Spurious done from an idle HPU -> hpu_done_ready_o stays 0, no feedback emitted.
